nios2_oci_dct_packer: RTL and testbench
=======================================

Name: nios2_oci_dct_packer

Overview:
Upstream packing stage for the Nios II OCI direct-compressed-trace (DCT) path. Accepts 2-bit branch atoms from the trace capture logic and packs them LSB-first into a 30-bit buffer with a 4-bit atom count. Emits completed frames over a valid/ready handshake. Also drives the live dct_buffer/dct_count and the test_has_ended status consumed by the OCI test bench.

Parameters:
MAX_ATOMS, 15, atoms per full frame; legal range 1..15.
TIMEOUT_CYCLES, 64, idle cycles before auto-flush; used only with DCT_TIMEOUT_FLUSH_EN; legal range 1..65535.

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
atom_valid  input  1  atom offered this cycle
atom  input  2  atom code: 01 taken, 10 not-taken, 11 exception; 00 is accepted and dropped, not packed
atom_ready  output  1  packer can accept an atom this cycle
flush  input  1  single-cycle request to emit the partial frame
test_ending  input  1  end-of-test request; latched
frame_valid  output  1  output frame register holds a frame
frame_ready  input  1  consumer accepts the frame
frame_buffer  output  30  packed atoms of the emitted frame
frame_count  output  4  atom count of the emitted frame, 1..MAX_ATOMS
dct_buffer  output  30  live accumulator contents
dct_count  output  4  live accumulator atom count
test_has_ended  output  1  sticky: ending latched and all data drained

Behaviour:
- Reset values: frame_valid=0, frame_buffer=0, frame_count=0, dct_buffer=0, dct_count=0, test_has_ended=0, ending latch=0, flush_pending=0. atom_ready=1 one cycle after reset deasserts.
- A transfer occurs when atom_valid && atom_ready. Atom k (0-based) is stored in dct_buffer[2k+1:2k]. Unused bits are 0.
- dct_* update on the clock edge after acceptance, so latency is 1 cycle.
- The output register is free when frame_valid=0, or when frame_valid && frame_ready in the same cycle.
- Emit: copy {dct_buffer, dct_count}, including any atom accepted this cycle, into the frame register. Set frame_valid=1 on the next edge and clear the accumulator to 0 on the same edge.
- Full emit: when the count after acceptance equals MAX_ATOMS and the output register is free, emit.
- If the accumulator is full and the output register is not free, atom_ready=0. The accumulator holds and emits as soon as the register frees.
- atom_ready = !ending_latch && !(dct_count==MAX_ATOMS && output register not free).
- Flush: a flush pulse sets flush_pending. While flush_pending=1, count>0 and the output register is free, emit and clear flush_pending.
- Flush with count==0 and no atom accepted that cycle clears flush_pending with no emit.
- Flush and atom in the same cycle: the atom is included in the flushed frame. If that atom completes the frame, exactly one frame is emitted.
- frame_valid stays high and frame_buffer/frame_count stay stable until frame_ready is sampled high. Back-to-back frames are allowed: a drain and a new emit in the same cycle keep frame_valid=1.
- test_ending sets ending_latch, which is sticky until reset. It behaves as a flush, and atom_ready=0 from the next cycle onward.
- test_has_ended=1 once ending_latch=1, dct_count==0, frame_valid=0 and flush_pending=0. It remains 1 until reset.
- Reset asserted mid-frame discards accumulator, frame register and latches. No partial frame is emitted.

Optional Feature:
DCT_TIMEOUT_FLUSH_EN
- Defined: a 16-bit idle counter increments each cycle that dct_count>0, no atom is accepted and no emit occurs. It clears on any acceptance or emit. When it reaches TIMEOUT_CYCLES, it sets flush_pending.
- Not defined: no counter is present, and partial frames leave only on flush, test_ending or full.

Test Plan:
- 15 atoms of 01 back-to-back, frame_ready=1 → one cycle after the 15th: frame_valid=1, frame_buffer=30'h15555555, frame_count=15, dct_count=0.
- Atoms 01,10,11, then flush pulse → frame_buffer=30'h00000039, frame_count=3. A second flush with the accumulator empty produces no frame.
- frame_ready=0, stream 31 atoms of 10 → first frame held stable at 30'h2AAAAAAA/15. The accumulator fills to 15 and atom_ready=0. Raising frame_ready drains the first frame, the second frame follows on the next cycle, and atom_ready returns to 1.
- Atom 11 and flush in the same cycle with count 2 (01,01) → single frame 30'h00000035, count 3.
- test_ending with count 4 and frame_ready=1 → 4-atom frame emitted, atom_ready=0. test_has_ended=1 on the cycle after the frame is drained, and stays 1 while test_ending is low.
- DCT_TIMEOUT_FLUSH_EN, TIMEOUT_CYCLES=8: one atom 01 then idle → frame 30'h1/1 emitted about 9–10 cycles later. Without the macro, no frame is emitted after 100 idle cycles.

Source files
------------

// File: rtl/nios2_oci_dct_packer.sv
// nios2_oci_dct_packer
// Packs 2-bit branch atoms LSB-first into a 30-bit accumulator and hands
// completed frames to a single output register over a valid/ready handshake.
//
// Handshakes:
//   atom side  - an atom transfers on a rising edge where atom_valid_i and
//                atom_ready_o are both high.
//   frame side - a frame transfers on a rising edge where frame_valid_o and
//                frame_ready_i are both high. While frame_valid_o is high the
//                frame contents never change until that transfer happens.
//
// Optional feature macro: DCT_TIMEOUT_FLUSH_EN
//   When defined, a 16-bit idle counter forces a flush of a partial frame
//   after TIMEOUT_CYCLES cycles without acceptance or emit.
//   When undefined, partial frames leave only on flush, test_ending or full.
module nios2_oci_dct_packer #(
    parameter int MAX_ATOMS      = 15,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        atom_valid,
    input  logic [1:0]  atom,
    output logic        atom_ready,
    input  logic        flush,
    input  logic        test_ending,
    output logic        frame_valid,
    input  logic        frame_ready,
    output logic [29:0] frame_buffer,
    output logic [3:0]  frame_count,
    output logic [29:0] dct_buffer,
    output logic [3:0]  dct_count,
    output logic        test_has_ended
);

    localparam logic [3:0] MAX_C = 4'(MAX_ATOMS);

    // Accumulator, output frame register and status latches
    logic [29:0] dct_buffer_q, dct_buffer_d;
    logic [3:0]  dct_count_q, dct_count_d;
    logic        frame_valid_q, frame_valid_d;
    logic [29:0] frame_buffer_q, frame_buffer_d;
    logic [3:0]  frame_count_q, frame_count_d;
    logic        ending_q, ending_d;
    logic        flush_pending_q, flush_pending_d;
    logic        has_ended_q, has_ended_d;

    // Combinational helpers
    logic        reg_free;
    logic        held_full;
    logic        accept;
    logic        pack;
    logic        flush_req;
    logic        emit;
    logic        timeout_hit;
    logic        done_now;
    logic [29:0] atom_ext;
    logic [29:0] buf_after;
    logic [3:0]  cnt_after;

    assign reg_free   = !frame_valid_q || frame_ready;
    // Accumulator holding a complete frame because the output register was busy
    assign held_full  = (dct_count_q == MAX_C);
    assign atom_ready = !ending_q && !(held_full && !reg_free);
    assign accept     = atom_valid && atom_ready;
    // Code 00 is consumed by the handshake but never occupies a slot
    assign pack       = accept && (atom != 2'b00);
    assign atom_ext   = {28'd0, atom};
    assign flush_req  = flush_pending_q || flush || test_ending || timeout_hit;

`ifdef DCT_TIMEOUT_FLUSH_EN
    logic [15:0] idle_q, idle_d;

    assign timeout_hit = (idle_q >= 16'(TIMEOUT_CYCLES));

    // Idle counter: counts cycles a partial frame sits untouched
    always_comb begin
        idle_d = idle_q;
        if (accept || emit) begin
            idle_d = 16'd0;
        end else if (dct_count_q != 4'd0 && idle_q != 16'hFFFF) begin
            idle_d = idle_q + 16'd1;
        end
    end

    // Idle counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            idle_q <= 16'd0;
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Packing and emit decision: what the accumulator and frame register load next
    always_comb begin
        emit            = 1'b0;
        cnt_after       = dct_count_q;
        buf_after       = dct_buffer_q;
        dct_buffer_d    = dct_buffer_q;
        dct_count_d     = dct_count_q;
        frame_buffer_d  = frame_buffer_q;
        frame_count_d   = frame_count_q;
        flush_pending_d = flush_req;

        if (held_full) begin
            // Full frame waiting on the output register; any atom accepted in
            // the freeing cycle starts the next frame.
            if (reg_free) begin
                emit            = 1'b1;
                frame_buffer_d  = dct_buffer_q;
                frame_count_d   = dct_count_q;
                dct_buffer_d    = pack ? atom_ext : 30'd0;
                dct_count_d     = pack ? 4'd1 : 4'd0;
                flush_pending_d = (flush || test_ending) && pack;
            end
        end else begin
            cnt_after    = dct_count_q + {3'd0, pack};
            buf_after    = pack ? (dct_buffer_q | (atom_ext << {dct_count_q, 1'b0}))
                                : dct_buffer_q;
            dct_buffer_d = buf_after;
            dct_count_d  = cnt_after;
            if (reg_free && (cnt_after == MAX_C || (flush_req && cnt_after != 4'd0))) begin
                emit            = 1'b1;
                frame_buffer_d  = buf_after;
                frame_count_d   = cnt_after;
                dct_buffer_d    = 30'd0;
                dct_count_d     = 4'd0;
                flush_pending_d = 1'b0;
            end else if (flush_req && cnt_after == 4'd0) begin
                flush_pending_d = 1'b0;
            end
        end
    end

    // Output register valid: set on emit, cleared when drained without refill
    always_comb begin
        frame_valid_d = frame_valid_q;
        if (emit) begin
            frame_valid_d = 1'b1;
        end else if (frame_ready) begin
            frame_valid_d = 1'b0;
        end
    end

    // End-of-test tracking: sticky latch and drained status
    assign done_now = ending_q && (dct_count_q == 4'd0) && !frame_valid_q && !flush_pending_q;
    always_comb begin
        ending_d    = ending_q || test_ending;
        has_ended_d = has_ended_q || done_now;
    end

    // State registers
    always_ff @(posedge clk) begin
        if (reset) begin
            dct_buffer_q    <= 30'd0;
            dct_count_q     <= 4'd0;
            frame_valid_q   <= 1'b0;
            frame_buffer_q  <= 30'd0;
            frame_count_q   <= 4'd0;
            ending_q        <= 1'b0;
            flush_pending_q <= 1'b0;
            has_ended_q     <= 1'b0;
        end else begin
            dct_buffer_q    <= dct_buffer_d;
            dct_count_q     <= dct_count_d;
            frame_valid_q   <= frame_valid_d;
            frame_buffer_q  <= frame_buffer_d;
            frame_count_q   <= frame_count_d;
            ending_q        <= ending_d;
            flush_pending_q <= flush_pending_d;
            has_ended_q     <= has_ended_d;
        end
    end

    assign frame_valid    = frame_valid_q;
    assign frame_buffer   = frame_buffer_q;
    assign frame_count    = frame_count_q;
    assign dct_buffer     = dct_buffer_q;
    assign dct_count      = dct_count_q;
    assign test_has_ended = has_ended_q || done_now;

endmodule

// File: tb/tb_nios2_oci_dct_packer.sv
// Bench for nios2_oci_dct_packer: table of atom sequences with expected
// frames, plus hand-written sequences for back-pressure, same-cycle
// flush, end-of-test, reset mid-frame and idle behaviour.
module tb_nios2_oci_dct_packer;

    logic        clk;
    logic        reset;
    logic        atom_valid;
    logic [1:0]  atom;
    logic        atom_ready;
    logic        flush;
    logic        test_ending;
    logic        frame_valid;
    logic        frame_ready;
    logic [29:0] frame_buffer;
    logic [3:0]  frame_count;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        test_has_ended;

    nios2_oci_dct_packer dut (
        .clk            (clk),
        .reset          (reset),
        .atom_valid     (atom_valid),
        .atom           (atom),
        .atom_ready     (atom_ready),
        .flush          (flush),
        .test_ending    (test_ending),
        .frame_valid    (frame_valid),
        .frame_ready    (frame_ready),
        .frame_buffer   (frame_buffer),
        .frame_count    (frame_count),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .test_has_ended (test_has_ended)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard: expected frames as {buffer, count}
    logic [33:0] exp_q[$];

    // Bench-side accumulator model (used while the output is never back-pressured)
    logic [29:0] m_buf;
    logic [3:0]  m_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Frame monitor: every cycle a frame is shown it must equal the queue head
    always @(negedge clk) begin
        if (!reset && frame_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_frame", {2'b0, frame_buffer}, 32'hFFFFFFFF);
            end else begin
                check("frame_buffer", {2'b0, frame_buffer}, {2'b0, exp_q[0][33:4]});
                check("frame_count", {28'd0, frame_count}, {28'd0, exp_q[0][3:0]});
                if (frame_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_atom(input logic [1:0] a, input bit chk);
        int guard;
        guard = 0;
        atom_valid = 1'b1;
        atom = a;
        while (!atom_ready && guard < 100) begin
            tick();
            guard++;
        end
        if (guard >= 100) check("atom_accept_timeout", guard, 0);
        tick();
        atom_valid = 1'b0;
        if (chk) begin
            if (a != 2'b00) begin
                m_buf = m_buf | ({28'd0, a} << (2 * m_cnt));
                m_cnt = m_cnt + 4'd1;
                if (m_cnt == 4'd15) begin
                    m_cnt = 4'd0;
                    m_buf = 30'd0;
                end
            end
            check("dct_count_live", {28'd0, dct_count}, {28'd0, m_cnt});
            check("dct_buffer_live", {2'b0, dct_buffer}, {2'b0, m_buf});
        end
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        m_cnt = 4'd0;
        m_buf = 30'd0;
    endtask

    task automatic wait_drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 60) begin
            tick();
            g++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    typedef struct {
        int          n;
        logic [5:0]  pat;
        bit          do_flush;
        logic [29:0] exp_buf;
        logic [3:0]  exp_cnt;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{15, 6'b01_01_01, 1'b0, 30'h15555555, 4'd15};
        vecs[1] = '{3,  6'b11_10_01, 1'b1, 30'h00000039, 4'd3};
        vecs[2] = '{5,  6'b11_11_11, 1'b1, 30'h000003FF, 4'd5};
        vecs[3] = '{15, 6'b10_10_10, 1'b0, 30'h2AAAAAAA, 4'd15};
        vecs[4] = '{2,  6'b10_01_10, 1'b1, 30'h00000006, 4'd2};
        vecs[5] = '{4,  6'b11_00_01, 1'b1, 30'h0000001D, 4'd3};
        vecs[6] = '{15, 6'b10_01_11, 1'b1, 30'h279E79E7, 4'd15};

        reset = 1'b1;
        atom_valid = 1'b0;
        atom = 2'b00;
        flush = 1'b0;
        test_ending = 1'b0;
        frame_ready = 1'b1;
        m_buf = 30'd0;
        m_cnt = 4'd0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Reset state
        check("rst_frame_valid", frame_valid, 0);
        check("rst_frame_buffer", {2'b0, frame_buffer}, 0);
        check("rst_frame_count", frame_count, 0);
        check("rst_dct_buffer", {2'b0, dct_buffer}, 0);
        check("rst_dct_count", dct_count, 0);
        check("rst_has_ended", test_has_ended, 0);
        check("rst_atom_ready", atom_ready, 1);

        // Table-driven sequences with the consumer always ready
        for (int v = 0; v < 7; v++) begin
            exp_q.push_back({vecs[v].exp_buf, vecs[v].exp_cnt});
            for (int i = 0; i < vecs[v].n; i++) begin
                logic [5:0] p;
                p = vecs[v].pat;
                send_atom(p[2*(i%3) +: 2], 1'b1);
            end
            if (vecs[v].n == 15) check("full_emit_valid", frame_valid, 1);
            if (vecs[v].do_flush) pulse_flush();
            wait_drain();
            check("acc_empty_after_vec", dct_count, 0);
        end

        // Flush with empty accumulator emits nothing
        pulse_flush();
        repeat (3) tick();
        check("empty_flush_no_frame", frame_valid, 0);

        // Back-pressure: 31 atoms of 10 with the consumer stalled
        frame_ready = 1'b0;
        exp_q.push_back({30'h2AAAAAAA, 4'd15});
        exp_q.push_back({30'h2AAAAAAA, 4'd15});
        for (int i = 0; i < 30; i++) send_atom(2'b10, 1'b0);
        check("held_dct_count", dct_count, 15);
        check("held_atom_ready", atom_ready, 0);
        atom_valid = 1'b1;
        atom = 2'b10;
        repeat (3) begin
            tick();
            check("held_atom_ready_stall", atom_ready, 0);
        end
        frame_ready = 1'b1;
        tick();
        atom_valid = 1'b0;
        check("release_frame_valid", frame_valid, 1);
        check("release_dct_count", dct_count, 1);
        check("release_dct_buffer", {2'b0, dct_buffer}, 2);
        check("release_atom_ready", atom_ready, 1);
        exp_q.push_back({30'h00000002, 4'd1});
        pulse_flush();
        wait_drain();

        // Atom and flush in the same cycle complete one frame
        send_atom(2'b01, 1'b0);
        send_atom(2'b01, 1'b0);
        exp_q.push_back({30'h00000035, 4'd3});
        flush = 1'b1;
        send_atom(2'b11, 1'b0);
        flush = 1'b0;
        wait_drain();
        check("same_cycle_acc_empty", dct_count, 0);

        // Idle behaviour with a single buffered atom
        send_atom(2'b01, 1'b0);
`ifdef DCT_TIMEOUT_FLUSH_EN
        exp_q.push_back({30'h00000001, 4'd1});
        repeat (100) tick();
        check("timeout_flushed", exp_q.size(), 0);
`else
        repeat (100) tick();
        check("no_timeout_dct_count", dct_count, 1);
        exp_q.push_back({30'h00000001, 4'd1});
        pulse_flush();
        wait_drain();
`endif

        // End of test with four atoms buffered
        for (int i = 0; i < 4; i++) send_atom(2'b01, 1'b0);
        exp_q.push_back({30'h00000055, 4'd4});
        test_ending = 1'b1;
        tick();
        test_ending = 1'b0;
        check("ending_atom_ready", atom_ready, 0);
        wait_drain();
        tick();
        check("has_ended", test_has_ended, 1);
        repeat (5) tick();
        check("has_ended_sticky", test_has_ended, 1);
        check("ending_atom_ready_sticky", atom_ready, 0);

        // Reset mid-frame discards everything
        reset = 1'b1;
        tick();
        reset = 1'b0;
        frame_ready = 1'b0;
        exp_q.push_back({30'h15555555, 4'd15});
        for (int i = 0; i < 17; i++) send_atom(2'b01, 1'b0);
        check("pre_reset_dct_count", dct_count, 2);
        reset = 1'b1;
        exp_q.delete();
        tick();
        tick();
        reset = 1'b0;
        frame_ready = 1'b1;
        tick();
        check("midrst_frame_valid", frame_valid, 0);
        check("midrst_dct_count", dct_count, 0);
        check("midrst_dct_buffer", {2'b0, dct_buffer}, 0);
        check("midrst_has_ended", test_has_ended, 0);
        check("midrst_atom_ready", atom_ready, 1);
        repeat (5) tick();
        check("midrst_no_frame", frame_valid, 0);

        check("final_queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
